// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: generates the 3-bit select {a,b,c} for a 3-to-8 decoder.
// A prescaler sets the step rate. The index then moves up, down or ping-pong,
// or holds. A synchronous load can place the index at any value.
// The direction register dir is the ping-pong FSM state.
module dec_sel_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  // Prescaler terminal count: a step happens on the edge where pre sits here.
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]       idx;
  logic [DIV_W-1:0] pre;
  dir_t             dir;
  logic             step;

  // A step is due when the prescaler is enabled and has reached its last count.
  assign step = en && (pre == PRE_LAST);

  // The select bits are the index register itself, so they are registered.
  assign {a, b, c} = idx;

  // Priority on each edge: reset, then load, then step or count.
  // A mode change is seen only at the next step and leaves pre untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 3'd0;
      pre  <= '0;
      dir  <= DIR_UP;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      idx  <= load_val;
      pre  <= '0;
      dir  <= DIR_UP;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      pre  <= '0;
      tick <= 1'b1;
      wrap <= 1'b0;
      case (mode)
        MODE_UP: begin
          idx  <= idx + 3'd1;
          wrap <= (idx == 3'd7);
        end
        MODE_DOWN: begin
          idx  <= idx - 3'd1;
          wrap <= (idx == 3'd0);
        end
        MODE_PING: begin
          // At an end the index reverses, so 7 and 0 are never repeated.
          case (dir)
            DIR_UP: begin
              if (idx == 3'd7) begin
                idx  <= 3'd6;
                dir  <= DIR_DOWN;
                wrap <= 1'b1;
              end else begin
                idx <= idx + 3'd1;
              end
            end
            DIR_DOWN: begin
              if (idx == 3'd0) begin
                idx  <= 3'd1;
                dir  <= DIR_UP;
                wrap <= 1'b1;
              end else begin
                idx <= idx - 3'd1;
              end
            end
            default: dir <= DIR_UP;
          endcase
        end
        default: ; // hold: tick still pulses, index and dir unchanged
      endcase
    end else if (en) begin
      pre  <= pre + DIV_W'(1);
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule
